// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the external 16-bit SRAM bridge
package sram_pkg;

    localparam int unsigned SRAM_AW   = 18;
    localparam int unsigned SRAM_DW   = 16;
    localparam int unsigned WORD_W    = SRAM_AW - 1;
    localparam logic [31:0] DATA_BASE = 32'd1024;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LO   = 2'b01,
        ST_HI   = 2'b10,
        ST_DONE = 2'b11
    } sram_state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// rtl/sram_wait_counter.sv - loadable down-counter with zero flag for half-word access timing
module sram_wait_counter #(
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Saturates at zero so the flag stays high while the FSM is idle.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/sram_controller.sv
// rtl/sram_controller.sv - 32-bit request port to 16-bit asynchronous SRAM, low half first
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter logic [31:0] DATA_BASE   = sram_pkg::DATA_BASE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  sram_address,
    input  logic [31:0]                  sram_write_data,
    input  logic                         sram_write_en,
    input  logic                         sram_read_en,
    output logic [31:0]                  sram_read_data,
    output logic                         sram_ready,
    inout  wire  [sram_pkg::SRAM_DW-1:0] SRAM_DQ,
    output logic [sram_pkg::SRAM_AW-1:0] SRAM_ADDR,
    output logic                         SRAM_WE_N,
    output logic                         SRAM_OE_N,
    output logic                         SRAM_CE_N,
    output logic                         SRAM_UB_N,
    output logic                         SRAM_LB_N
);

    import sram_pkg::*;

    localparam int unsigned CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

    sram_state_e        state_q, state_d;
    logic               is_write_q, is_write_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] addr_q, addr_d;

    logic               cnt_load;
    logic               cnt_zero;
    logic               in_access;

    logic [31:0]        req_offset;
    logic [WORD_W-1:0]  req_word;
    logic               unused_offset_bits;

    // Addresses below the base or past the array simply wrap within 2^17 words.
    assign req_offset         = sram_address - DATA_BASE;
    assign req_word           = req_offset[18:2];
    assign unused_offset_bits = ^{req_offset[31:19], req_offset[1:0]};

    sram_wait_counter #(
        .WIDTH(CW)
    ) u_wait_counter (
        .clk       (clk),
        .resetn    (rst),
        .load      (cnt_load),
        .load_value(LOAD_VAL),
        .zero      (cnt_zero)
    );

    always_comb begin
        state_d    = state_q;
        is_write_d = is_write_q;
        word_d     = word_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        addr_d     = addr_q;
        cnt_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (sram_write_en || sram_read_en) begin
                    is_write_d = sram_write_en;
                    word_d     = req_word;
                    wdata_d    = sram_write_data;
                    addr_d     = {req_word, 1'b0};
                    cnt_load   = 1'b1;
                    state_d    = ST_LO;
                end
            end
            ST_LO: begin
                if (cnt_zero) begin
                    if (!is_write_q) begin
                        rdata_d[15:0] = SRAM_DQ;
                    end
                    addr_d   = {word_q, 1'b1};
                    cnt_load = 1'b1;
                    state_d  = ST_HI;
                end
            end
            ST_HI: begin
                if (cnt_zero) begin
                    if (!is_write_q) begin
                        rdata_d[31:16] = SRAM_DQ;
                    end
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            is_write_q <= 1'b0;
            word_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            is_write_q <= is_write_d;
            word_q     <= word_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            addr_q     <= addr_d;
        end
    end

    assign in_access = (state_q == ST_LO) || (state_q == ST_HI);

    // WE_N rises in the last cycle of each phase while address and data stay put.
    assign SRAM_WE_N = !(in_access && is_write_q && !cnt_zero);
    assign SRAM_OE_N = !(in_access && !is_write_q);
    assign SRAM_DQ   = (in_access && is_write_q)
                       ? ((state_q == ST_LO) ? wdata_q[15:0] : wdata_q[31:16])
                       : 16'hzzzz;

    assign SRAM_ADDR      = addr_q;
    assign SRAM_CE_N      = 1'b0;
    assign SRAM_UB_N      = 1'b0;
    assign SRAM_LB_N      = 1'b0;
    assign sram_read_data = rdata_q;
    assign sram_ready     = (state_q == ST_DONE);

endmodule

// File: tb/tb_sram_controller.sv
// tb/tb_sram_controller.sv - self-checking bench for sram_controller with a behavioural SRAM
module tb_sram_controller;

    localparam int W  = 5;
    localparam int NC = 2 * W + 3;

    typedef struct {
        logic        rd;
        logic [31:0] data;
    } sb_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [17:0] exp_addr;
        logic [31:0] exp_rd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] sram_address = '0;
    logic [31:0] sram_write_data = '0;
    logic        sram_write_en = 1'b0;
    logic        sram_read_en = 1'b0;
    logic [31:0] sram_read_data;
    logic        sram_ready;
    wire  [15:0] SRAM_DQ;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;
    logic        SRAM_OE_N;
    logic        SRAM_CE_N;
    logic        SRAM_UB_N;
    logic        SRAM_LB_N;

    logic [15:0] mem [0:262143];

    int          checks = 0;
    int          errors = 0;
    sb_t         sb_q[$];
    logic [31:0] last_rd = '0;
    vec_t        vecs[9];

    always #5 clk = ~clk;

    sram_controller #(
        .WAIT_CYCLES(W),
        .DATA_BASE  (32'd1024)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .sram_address   (sram_address),
        .sram_write_data(sram_write_data),
        .sram_write_en  (sram_write_en),
        .sram_read_en   (sram_read_en),
        .sram_read_data (sram_read_data),
        .sram_ready     (sram_ready),
        .SRAM_DQ        (SRAM_DQ),
        .SRAM_ADDR      (SRAM_ADDR),
        .SRAM_WE_N      (SRAM_WE_N),
        .SRAM_OE_N      (SRAM_OE_N),
        .SRAM_CE_N      (SRAM_CE_N),
        .SRAM_UB_N      (SRAM_UB_N),
        .SRAM_LB_N      (SRAM_LB_N)
    );

    // Released bus reads back as all ones.
    pullup pu_dq (SRAM_DQ);
    assign SRAM_DQ = !SRAM_OE_N ? mem[SRAM_ADDR] : 16'hzzzz;

    always @(posedge clk) begin
        if (!SRAM_WE_N) mem[SRAM_ADDR] <= SRAM_DQ;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        sb_t e;
        @(negedge clk);
        if (sram_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ready got 1 expected 0");
            end else begin
                e = sb_q.pop_front();
                if (e.rd) check("sb_read_data", sram_read_data, e.data);
            end
        end
    endtask

    task automatic run_req(input vec_t v);
        logic [NC-1:0] wm, om, rm, ewm, eom, erm;
        logic          lo, hi, last;
        @(posedge clk);
        #1;
        sram_write_en   = v.we;
        sram_read_en    = v.re;
        sram_address    = v.addr;
        sram_write_data = v.wdata;
        sb_q.push_back('{rd: !v.we, data: v.exp_rd});
        for (int c = 0; c < NC; c++) begin
            tick();
            wm[c]  = !SRAM_WE_N;
            om[c]  = !SRAM_OE_N;
            rm[c]  = sram_ready;
            lo     = (c >= 1) && (c <= W);
            hi     = (c >= W + 1) && (c <= 2 * W);
            last   = (c == W) || (c == 2 * W);
            ewm[c] = v.we && (lo || hi) && !last;
            eom[c] = !v.we && (lo || hi);
            erm[c] = (c == 2 * W + 1);
            if (c == 1) check("addr_lo", SRAM_ADDR, v.exp_addr);
            if (c == W + 1) check("addr_hi", SRAM_ADDR, v.exp_addr + 18'd1);
            if (c == 2 * W + 1) begin
                check("addr_hold_done", SRAM_ADDR, v.exp_addr + 18'd1);
                check("dq_released_done", SRAM_DQ, 16'hFFFF);
            end
            if (v.we && c == 1) check("dq_write_lo", SRAM_DQ, v.wdata[15:0]);
            if (v.we && c == W + 1) check("dq_write_hi", SRAM_DQ, v.wdata[31:16]);
            if (c == 1) begin
                sram_write_en   = 1'b0;
                sram_read_en    = 1'b0;
                sram_address    = 32'hFFFF_FFF0;
                sram_write_data = 32'h0;
            end
        end
        check("we_low_cycles", wm, ewm);
        check("oe_low_cycles", om, eom);
        check("ready_cycles", rm, erm);
        if (v.we) begin
            check("mem_lo", mem[v.exp_addr], v.wdata[15:0]);
            check("mem_hi", mem[v.exp_addr + 18'd1], v.wdata[31:16]);
        end else begin
            last_rd = v.exp_rd;
        end
        check("read_data_hold", sram_read_data, last_rd);
    endtask

    initial begin
        logic [26:0] rm2;
        logic [26:0] erm2;
        logic [NC-1:0] wm3;
        logic [NC-1:0] rm3;

        vecs[0] = '{1'b1, 1'b0, 32'h0000_0400, 32'h1234_ABCD, 18'h00000, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 32'h0000_0400, 32'h0,         18'h00000, 32'h1234_ABCD};
        vecs[2] = '{1'b1, 1'b1, 32'h0000_0500, 32'hCAFE_F00D, 18'h00080, 32'h0};
        vecs[3] = '{1'b0, 1'b1, 32'h0000_0500, 32'h0,         18'h00080, 32'hCAFE_F00D};
        vecs[4] = '{1'b1, 1'b0, 32'h0008_03FC, 32'h55AA_33CC, 18'h3FFFE, 32'h0};
        vecs[5] = '{1'b0, 1'b1, 32'h0008_03FC, 32'h0,         18'h3FFFE, 32'h55AA_33CC};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,         18'h3FFFE, 32'h55AA_33CC};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0404, 32'hDEAD_BEEF, 18'h00002, 32'h0};
        vecs[8] = '{1'b0, 1'b1, 32'h0000_0404, 32'h0,         18'h00002, 32'hDEAD_BEEF};

        repeat (3) tick();
        check("rst_ready", sram_ready, 1'b0);
        check("rst_read_data", sram_read_data, 32'h0);
        check("rst_addr", SRAM_ADDR, 18'h0);
        check("rst_we_n", SRAM_WE_N, 1'b1);
        check("rst_oe_n", SRAM_OE_N, 1'b1);
        check("rst_dq", SRAM_DQ, 16'hFFFF);
        check("tie_offs", {SRAM_CE_N, SRAM_UB_N, SRAM_LB_N}, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 9; i++) run_req(vecs[i]);

        // Read enable held across two requests; address steps after the first ready.
        @(posedge clk);
        #1;
        sram_read_en = 1'b1;
        sram_address = 32'h0000_0400;
        sb_q.push_back('{rd: 1'b1, data: 32'h1234_ABCD});
        sb_q.push_back('{rd: 1'b1, data: 32'hDEAD_BEEF});
        erm2 = '0;
        erm2[2 * W + 1] = 1'b1;
        erm2[4 * W + 3] = 1'b1;
        for (int c = 0; c < 27; c++) begin
            tick();
            rm2[c] = sram_ready;
            if (c == 1) check("b2b_addr0", SRAM_ADDR, 18'd0);
            if (c == W + 1) check("b2b_addr1", SRAM_ADDR, 18'd1);
            if (c == 2 * W + 3) check("b2b_addr2", SRAM_ADDR, 18'd2);
            if (c == 3 * W + 3) check("b2b_addr3", SRAM_ADDR, 18'd3);
            if (c == 2 * W + 1) sram_address = 32'h0000_0404;
            if (c == 4 * W + 3) sram_read_en = 1'b0;
        end
        check("b2b_ready_cycles", rm2, erm2);
        check("b2b_read_data", sram_read_data, 32'hDEAD_BEEF);
        last_rd = 32'hDEAD_BEEF;

        // Reset asserted in cycle 7 of a write; no completion is expected.
        @(posedge clk);
        #1;
        sram_write_en   = 1'b1;
        sram_address    = 32'h0000_0408;
        sram_write_data = 32'h1111_2222;
        for (int c = 0; c < NC; c++) begin
            tick();
            wm3[c] = !SRAM_WE_N;
            rm3[c] = sram_ready;
            if (c == 1) sram_write_en = 1'b0;
            if (c == 7) begin
                check("pre_reset_we_low", SRAM_WE_N, 1'b0);
                rst = 1'b0;
            end
            if (c == 8) begin
                check("post_reset_dq", SRAM_DQ, 16'hFFFF);
                rst = 1'b1;
            end
            if (c == 9) begin
                check("post_reset_read_data", sram_read_data, 32'h0);
                check("post_reset_addr", SRAM_ADDR, 18'h0);
            end
        end
        check("post_reset_we_strobes", wm3[NC-1:8], 5'b00000);
        check("reset_no_ready", rm3, '0);
        last_rd = 32'h0;

        run_req(vecs[1]);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bridges the cache controller's 32-bit SRAM request port to the board's external 16-bit asynchronous SRAM. Each 32-bit request becomes two timed half-word accesses, low half first, with a fixed wait-state count per half. The block completes each request with a single-cycle `sram_ready` pulse and, for reads, the assembled 32-bit word. It sits directly downstream of the cache controller and is the only driver of the SRAM pins.

## Interface
- `WAIT_CYCLES`, default 5: cycles per half-word access, minimum 2.
- `DATA_BASE`, default 1024: byte address that maps to SRAM word 0.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-low.
- `sram_address` in 32: byte address, word aligned.
- `sram_write_data` in 32: write word.
- `sram_write_en` in 1: write request.
- `sram_read_en` in 1: read request.
- `sram_read_data` out 32: registered read word.
- `sram_ready` out 1: one-cycle completion pulse.
- `SRAM_DQ` inout 16: SRAM data bus.
- `SRAM_ADDR` out 18: SRAM half-word address.
- `SRAM_WE_N`, `SRAM_OE_N` out 1 each: active-low strobes.
- `SRAM_CE_N`, `SRAM_UB_N`, `SRAM_LB_N` out 1 each: tied to 0.

## Operation
- **States:** IDLE, LO, HI, DONE.
- **IDLE:**
  - If `sram_write_en` or `sram_read_en` is 1, latch the address, data and direction, then go to LO.
  - If both are 1, the write wins.
- **LO and HI:**
  - Each state lasts exactly `WAIT_CYCLES` cycles, timed by a down-counter loaded with `WAIT_CYCLES-1` on entry.
  - When the count reaches 0, go to the next state: LO goes to HI, HI goes to DONE.
- **DONE:** `sram_ready`=1 for this one cycle, then IDLE. A request that is still asserted is re-sampled in IDLE on the following cycle.
- **Address mapping:**
  - word = (`sram_address` − `DATA_BASE`)[18:2], 17 bits.
  - `SRAM_ADDR` = {word, 0} in LO and {word, 1} in HI.
  - Out-of-range addresses wrap modulo 2^17 words; there is no error.
- **Write:**
  - `SRAM_DQ` drives write_data[15:0] in LO and [31:16] in HI.
  - `SRAM_WE_N`=0 in the first `WAIT_CYCLES`−1 cycles of each phase and 1 in the last cycle; address and data stay stable for hold time.
  - `SRAM_OE_N`=1 throughout.
- **Read:**
  - `SRAM_OE_N`=0 during LO and HI, and `SRAM_DQ` is released (Z).
  - `SRAM_DQ` is captured on the last cycle of LO into read_data[15:0] and on the last cycle of HI into [31:16].
  - `sram_read_data` is valid in the DONE cycle and holds until the next read capture. Writes do not alter it.
- **Mid-access request changes:** the request is latched at accept. Deasserting the enables, or changing address or data, mid-access has no effect; the access completes and `sram_ready` still pulses.
- **Outside LO/HI:** `SRAM_DQ`=Z, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_ADDR` holds its last value.

## Timing
- **Cycle numbering:** cycle 0 is the IDLE cycle in which the request is accepted.
- **Phases:** LO occupies cycles 1..W, HI occupies cycles W+1..2W, and `sram_ready`=1 in cycle 2W+1. With W=5, LO is cycles 1–5, HI is 6–10 and ready is in cycle 11.
- **Throughput:** a request held continuously is accepted again in cycle 2W+2. Ready pulses are therefore 2W+2 cycles apart (12 at W=5).
- **Requester handshake:** the requester may change address or enable on the edge after the `sram_ready` cycle.
- **Reset values:** state IDLE, `sram_ready`=0, `sram_read_data`=0, `SRAM_ADDR`=0, `SRAM_WE_N`=1, `SRAM_OE_N`=1, `SRAM_DQ`=Z, counter 0.
- **Reset mid-access:** applies on the next edge. The access is abandoned with no ready pulse, and no further SRAM write strobes occur.

## Structure
- **Shared package** `sram_pkg`: state encoding (IDLE=2'b00, LO=2'b01, HI=2'b10, DONE=2'b11), `DATA_BASE`, SRAM address width 18 and data width 16.
- **Sub-module** `sram_wait_counter`: a loadable down-counter with a zero flag. The FSM, address mapping and data muxes stay in the top module.

## Test plan
Behavioural SRAM model, W=5.
- **Write:** write 0x1234ABCD at 0x400 → SRAM[0]=0xABCD and SRAM[1]=0x1234; `SRAM_WE_N`=0 in cycles 1–4 and 6–9; `sram_ready` high only in cycle 11.
- **Read:** read 0x400 after the write above → `SRAM_OE_N`=0 in cycles 1–10; `sram_read_data`=0x1234ABCD in cycle 11 and held afterwards.
- **Back-to-back reads:** `sram_read_en` held while the address steps 0x400 then 0x404 → ready pulses in cycles 11 and 23; SRAM_ADDR 0/1, then 2/3.
- **Simultaneous request:** `sram_read_en`=`sram_write_en`=1 at 0x500 with data 0xCAFEF00D → write to SRAM[0x80]=0xF00D and SRAM[0x81]=0xCAFE; `SRAM_OE_N` stays 1.
- **Reset mid-write:** `rst`=0 in cycle 7 of a write → from cycle 8 `SRAM_WE_N`=1 and `SRAM_DQ`=Z, with no ready pulse. A following read at 0x400 completes normally.
- **Top of range:** read at 0x400+0x7FFFC → `SRAM_ADDR` 0x3FFFE then 0x3FFFF.
